// File: rtl/barrel_rot_pkg.sv
// Shared constants and slot payload type for the pipelined 32-bit barrel rotator.
package barrel_rot_pkg;

    localparam int unsigned ROT_WIDTH = 32;
    localparam int unsigned ROT_AMT_W = 5;

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;

    // Payload of the first pipeline slot: partially rotated word plus the work still to do.
    typedef struct packed {
        logic [ROT_WIDTH-1:0] data;
        logic [1:0]           amt_hi;
        logic                 dir;
    } slot_t;

endpackage

// File: rtl/barrel_rot_pipe_rot_stage.sv
// One combinational rotate stage: rotates by SHIFT bits in the requested direction when enabled.
module rot_stage
    import barrel_rot_pkg::*;
#(
    parameter int unsigned SHIFT = 1,
    parameter int unsigned WIDTH = ROT_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             ena,
    input  logic             dir,
    output logic [WIDTH-1:0] data_c
);

    always_comb begin
        data_c = data_i;
        if (ena) begin
            if (dir == ROT_RIGHT) begin
                data_c = {data_i[SHIFT-1:0], data_i[WIDTH-1:SHIFT]};
            end else begin
                data_c = {data_i[WIDTH-SHIFT-1:0], data_i[WIDTH-1:WIDTH-SHIFT]};
            end
        end
    end

endmodule

// File: rtl/barrel_rot_pipe.sv
// Pipelined 32-bit barrel rotator with valid/ready flow control.
// BARREL_ROT_MID_REG_EN adds a second slot between the 4-bit and 8-bit stages (latency 2 instead of 1).
module barrel_rot_pipe
    import barrel_rot_pkg::*;
#(
    parameter int unsigned WIDTH = ROT_WIDTH,
    parameter int unsigned AMT_W = ROT_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] s1_data, s2_data, s4_data, s8_data, s16_data;
    logic [WIDTH-1:0] hi_src;
    logic [1:0]       hi_amt;
    logic             hi_dir;

    rot_stage #(.SHIFT(1), .WIDTH(WIDTH)) u_stage1 (
        .data_i(in_data), .ena(in_amt[0]), .dir(in_dir), .data_c(s1_data)
    );
    rot_stage #(.SHIFT(2), .WIDTH(WIDTH)) u_stage2 (
        .data_i(s1_data), .ena(in_amt[1]), .dir(in_dir), .data_c(s2_data)
    );
    rot_stage #(.SHIFT(4), .WIDTH(WIDTH)) u_stage4 (
        .data_i(s2_data), .ena(in_amt[2]), .dir(in_dir), .data_c(s4_data)
    );
    rot_stage #(.SHIFT(8), .WIDTH(WIDTH)) u_stage8 (
        .data_i(hi_src), .ena(hi_amt[0]), .dir(hi_dir), .data_c(s8_data)
    );
    rot_stage #(.SHIFT(16), .WIDTH(WIDTH)) u_stage16 (
        .data_i(s8_data), .ena(hi_amt[1]), .dir(hi_dir), .data_c(s16_data)
    );

`ifdef BARREL_ROT_MID_REG_EN
    slot_t            a_q, a_d;
    logic             va_q, va_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             vb_q, vb_d;
    logic             load_a, load_b;

    assign hi_src = a_q.data;
    assign hi_amt = a_q.amt_hi;
    assign hi_dir = a_q.dir;

    // Ready ripples back combinationally from the output so a full pipe still moves every cycle.
    always_comb begin
        load_b = !vb_q || out_ready;
        load_a = !va_q || load_b;
        va_d   = va_q;
        a_d    = a_q;
        vb_d   = vb_q;
        b_d    = b_q;
        if (load_a) begin
            va_d = in_valid;
            if (in_valid) begin
                a_d.data   = s4_data;
                a_d.amt_hi = in_amt[4:3];
                a_d.dir    = in_dir;
            end
        end
        if (load_b) begin
            vb_d = va_q;
            if (va_q) begin
                b_d = s16_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            va_q <= 1'b0;
            b_q  <= '0;
            vb_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            va_q <= va_d;
            b_q  <= b_d;
            vb_q <= vb_d;
        end
    end

    assign in_ready  = load_a;
    assign out_valid = vb_q;
    assign out_data  = b_q;
`else
    logic [WIDTH-1:0] data_q, data_d;
    logic             v_q, v_d;
    logic             load;

    assign hi_src = s4_data;
    assign hi_amt = in_amt[4:3];
    assign hi_dir = in_dir;

    always_comb begin
        load   = !v_q || out_ready;
        v_d    = v_q;
        data_d = data_q;
        if (load) begin
            v_d = in_valid;
            if (in_valid) begin
                data_d = s16_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            v_q    <= 1'b0;
        end else begin
            data_q <= data_d;
            v_q    <= v_d;
        end
    end

    assign in_ready  = load;
    assign out_valid = v_q;
    assign out_data  = data_q;
`endif

endmodule

// File: tb/tb_barrel_rot_pipe.sv
// Scoreboard bench for barrel_rot_pipe: directed vectors, handshake corner cases and random traffic.
module tb_barrel_rot_pipe;

`ifdef BARREL_ROT_MID_REG_EN
    localparam int LAT   = 2;
    localparam int DEPTH = 2;
`else
    localparam int LAT   = 1;
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    logic [31:0] cur_exp;
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] held = '0;

    barrel_rot_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Reference rotate: take a 32-bit window out of the word concatenated with itself.
    function automatic logic [31:0] ref_rot(logic [31:0] d, int n, logic right);
        logic [63:0] dd;
        dd = {d, d};
        if (right) return 32'(dd >> n);
        dd = dd << n;
        return dd[63:32];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: records accepted requests and checks every delivered result in order.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("hold_stable", out_data, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%08h with empty scoreboard at %0t",
                             out_data, $time);
                end else begin
                    chk("out_data", out_data, sb.pop_front());
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                n_acc++;
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
        end
    end

    task automatic drive(logic [31:0] d, logic [4:0] a, logic dr, logic [31:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        cur_exp  = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic latency_test(logic [31:0] d, logic [4:0] a, logic dr, logic [31:0] e);
        int cnt;
        drive(d, a, dr, e);
        @(posedge clk);
        #1 idle();
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk("latency", 32'(cnt), 32'(LAT));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        int cyc;
        out_ready = 1'b1;
        idle();
        cyc = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n0, acc0, cyc;
        logic [31:0] d;
        logic [4:0]  a;
        logic        dr;

        rst = 1'b1; out_ready = 1'b0; cur_exp = '0;
        in_data = 32'hFFFF_FFFF; in_amt = '0; in_dir = 1'b0;
        in_valid = 1'b1;                       // must be ignored while in reset
        repeat (3) @(posedge clk);
        #1 chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'h0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1 chk("reset_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("no_output_after_reset", 32'(out_valid), 32'd0);

        // Directed vectors with hand-computed results
        latency_test(32'h1234_5678, 5'd4,  1'b1, 32'h8123_4567);
        latency_test(32'h1234_5678, 5'd4,  1'b0, 32'h2345_6781);
        latency_test(32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF);
        latency_test(32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF);
        latency_test(32'h8000_0001, 5'd31, 1'b0, 32'hC000_0000);
        latency_test(32'hAAAA_5555, 5'd16, 1'b1, 32'h5555_AAAA);
        latency_test(32'h8000_0001, 5'd31, 1'b1, 32'h0000_0003);
        drain("directed_drain");

        // Back-to-back: one result per cycle, 1,2,4,...,0x80 in order
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            drive(32'h1, 5'(i), 1'b0, 32'h1 << i);
            #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        idle();
        repeat (LAT) @(negedge clk);
        #1 chk("b2b_count", 32'(n_out - n0), 32'd8);
        drain("b2b_drain");

        // Backpressure: accepts stop once every slot is full, output held
        out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            d = $urandom; a = 5'($urandom); dr = 1'($urandom);
            drive(d, a, dr, ref_rot(d, int'(a), dr));
            @(posedge clk);
            #1;
        end
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_accepts", 32'(n_acc - acc0), 32'(DEPTH));
        idle();
        @(posedge clk);
        #1 drain("bp_drain");

        // Reset mid-flight: in-flight requests vanish
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(32'hCAFE_0000 | 32'(i), 5'd3, 1'b0, 32'h0);
            @(posedge clk);
            #1;
        end
        idle();
        #2 rst = 1'b1;
        #1 chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'h0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (6) @(posedge clk);
        #1 chk("midrst_nothing_emerges", 32'(n_out - n0), 32'd0);

        // Random traffic against the reference model
        acc0 = n_acc;
        cyc  = 0;
        while (n_acc - acc0 < 10000 && cyc < 60000) begin
            if (!in_valid || in_ready || ($urandom_range(0, 3) == 0)) begin
                if ($urandom_range(0, 9) < 7) begin
                    d = $urandom; a = 5'($urandom); dr = 1'($urandom);
                    drive(d, a, dr, ref_rot(d, int'(a), dr));
                end else begin
                    idle();
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1 cyc++;
        end
        chk("random_accept_count", 32'(n_acc - acc0), 32'd10000);
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barrel_rot_pipe.md
# barrel_rot_pipe

Pipelined 32-bit barrel rotator that sits between an upstream valid/ready producer and a downstream consumer. It cascades the power-of-two rotate stages (1, 2, 4, 8 and 16 bits) behind registered pipeline slots, with per-slot valid/ready flow control. The 5-bit shift amount decodes directly into the per-stage enables. Throughput is one rotation per cycle; latency is 1 or 2 cycles depending on configuration.

## Interface
- `WIDTH`, 32: data width; fixed at 32, and other values are not supported.
- `AMT_W`, 5: shift-amount width, equal to log2(WIDTH).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: upstream request valid.
- `in_ready` output 1: block can accept a request this cycle.
- `in_data` input 32: word to rotate.
- `in_amt` input 5: rotate amount, 0..31.
- `in_dir` input 1: 1 = rotate right, 0 = rotate left.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output 32: rotated word.

## Operation
- A request transfers on a cycle where `in_valid && in_ready`. `in_data`, `in_amt` and `in_dir` are sampled on that edge.
- Stage k (shift 2^k) is enabled by `in_amt[k]`. An enabled stage rotates by 2^k in the direction set by `in_dir`; a disabled stage passes data through.
  - Right rotate by n: result = {d[n-1:0], d[31:n]}.
  - Left rotate by n: result = {d[31-n:0], d[31:32-n]}.
- The net result is a rotation by `in_amt` bits. An amount of 0 returns the input unchanged.
- Pipeline slot A holds the output of stages 1, 2 and 4 plus the carried `amt[4:3]` and `dir`. With the mid register enabled, slot B holds the output of stages 8 and 16.
- Each slot has a valid bit.
  - A slot loads when it is empty or its content is leaving this cycle: load_k = !v_k || ready_{k+1}.
  - `in_ready` = load of the first slot. The ready path back from `out_ready` is combinational.
  - The last slot drives `out_valid` and `out_data` directly from registers.
- A result leaves on `out_valid && out_ready`. A new result may enter the same slot on that same edge, so the pipeline sustains full throughput.
- Backpressure: while `out_valid && !out_ready`, `out_data` is held stable. Once every slot is full, `in_ready` = 0.
- Requests are never dropped, duplicated or reordered.

## Timing
- Reset (asynchronous, takes effect immediately):
  - all valid bits = 0, so `out_valid` = 0;
  - all data registers = 0, so `out_data` = 0x00000000;
  - `in_ready` = 1 once reset is low.
- Latency is measured from the accept edge to `out_valid` high.
  - With the mid register: 2 cycles; result visible after the 2nd edge.
  - Without the mid register: 1 cycle.
- Reset asserted mid-operation discards all in-flight requests. No partial result appears after release.
- `in_valid` asserted during reset is ignored.
- Accept and drain on the same edge with the pipeline full: both happen, and occupancy stays unchanged.

## Configuration
- Macro `BARREL_ROT_MID_REG_EN`.
- Defined: two slots (A after stages 1/2/4, B after stages 8/16). Latency 2; maximum occupancy 2.
- Undefined: one slot after all five stages. Latency 1; maximum occupancy 1.
- Handshake rules are identical in both builds.

## Structure
- Shared package `barrel_rot_pkg` contains:
  - `ROT_WIDTH` = 32 and `ROT_AMT_W` = 5;
  - direction constants `ROT_LEFT` = 1'b0 and `ROT_RIGHT` = 1'b1;
  - a struct typedef for the slot payload: data, remaining amount bits, dir.
- One sub-module, `rot_stage`:
  - parameterised by shift distance `SHIFT` (1, 2, 4, 8, 16);
  - purely combinational;
  - ports: data in, ena, dir, data out;
  - instantiated five times.

## Test plan
- 0x12345678, amt 4, dir 1 → `out_data` 0x81234567; dir 0 → 0x23456781. Latency 2 (macro on) or 1 (macro off).
- amt 0, 0xDEADBEEF, either dir → 0xDEADBEEF. amt 31, 0x80000001, dir 0 → 0xC0000000. amt 16, dir 1, 0xAAAA5555 → 0x5555AAAA.
- Back-to-back: 8 requests, amt 0..7, data 0x00000001, dir 0, `out_ready` = 1 → outputs 0x1, 0x2, 0x4 … 0x80, one per cycle, in order.
- Backpressure: hold `out_ready` = 0 for 5 cycles while feeding requests.
  - `in_ready` falls after 2 accepts (macro on) or 1 accept (macro off).
  - `out_data` stays stable.
  - After release, all accepted results drain in order with none lost.
- Reset mid-flight: assert `rst` with 2 requests in flight → `out_valid` = 0 and `out_data` = 0 immediately; nothing emerges after release.
- Random: 10k requests with random `in_valid`/`out_ready` → every output matches a reference rotate model in order.
